decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 D_stall, D_bubble  in  1 each  pipeline control for the D register.
REQ-006 f_stat  in  3  fetch status (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-007 f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched instruction fields.
REQ-008 f_valC, f_valP  in  64 each  fetched constant and next-PC.
REQ-009 e_dstE  in  4 / e_valE  in  64  execute-stage forwarding source.
REQ-010 M_dstE, M_dstM  in  4 each / M_valE, m_valM  in  64 each  memory-stage forwarding sources.
REQ-011 W_dstE, W_dstM  in  4 each / W_valE, W_valM  in  64 each  write-back ports and forwarding sources.
REQ-012 D_stat  out  3; D_icode, D_ifun  out  4 each; D_valC, D_valP  out  64 each  registered D-stage fields.
REQ-013 d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs (15 = none).
REQ-014 d_valA, d_valB  out  64 each  forwarded operand values.

Function
REQ-015 The D register SHALL capture all seven f_* fields on each rising clk when D_stall=0 and D_bubble=0.
REQ-016 D_stall=1 SHALL hold every D field unchanged, and SHALL take priority over D_bubble.
REQ-017 D_bubble=1 with D_stall=0 SHALL load a nop: stat=1, icode=1, ifun=0, rA=rB=15, valC=0, valP=0.
REQ-018 The register file SHALL contain 15 registers of 64 bits, IDs 0-14; ID 4 is rsp.
REQ-019 A read of ID 15 SHALL return 0; reads SHALL be combinational.
REQ-020 On a rising clk, W_valE SHALL be written to W_dstE and W_valM to W_dstM; writes to ID 15 are ignored.
REQ-021 When W_dstE equals W_dstM (not 15), W_valM SHALL win.
REQ-022 d_srcA SHALL be D_rA for icode 2, 4, 6, A; 4 for icode 9, B; 15 otherwise.
REQ-023 d_srcB SHALL be D_rB for icode 4, 5, 6; 4 for icode 8, 9, A, B; 15 otherwise.
REQ-024 d_dstE SHALL be D_rB for icode 2, 3, 6; 4 for icode 8, 9, A, B; 15 otherwise.
REQ-025 d_dstM SHALL be D_rA for icode 5, B; 15 otherwise.
REQ-026 d_valA priority SHALL be: D_valP if icode is 7 or 8; then e_valE (e_dstE), m_valM (M_dstM), M_valE (M_dstE), W_valM (W_dstM), W_valE (W_dstE); otherwise the register file value.
REQ-027 d_valB SHALL follow the same priority as d_valA, using d_srcB and without the D_valP term.
REQ-028 A source of 15 SHALL never match a forwarding tag and SHALL yield 0.
REQ-029 Decode and forwarding outputs SHALL be combinational from the D register, the register file and the forwarding inputs, with zero added latency; D outputs have 1-cycle latency from f_*.
REQ-030 An icode of C-F SHALL decode all four IDs to 15 and pass through D_stat unchanged.

Reset
REQ-031 rst_n=0 SHALL immediately clear all 15 registers to 0 and load the nop bubble values into the D register, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard any pending write and take precedence over stall and bubble.
REQ-033 After rst_n is released, the first rising clk SHALL behave per REQ-015 to REQ-017.

Verification
REQ-034 Reset, then f_icode=6, f_rA=2, f_rB=3, with r2=5, r3=7 written previously via the W port -> after 1 clk: d_valA=5, d_valB=7, d_dstE=3, d_srcA=2.
REQ-035 e_dstE=2, e_valE=0x11, M_dstM=2, m_valM=0x22, decode uses srcA=2 -> d_valA=0x11; drop e_dstE to 15 -> d_valA=0x22.
REQ-036 f_icode=8, f_valC=0x100, f_valP=0x109 -> d_valA=0x109, d_srcB=4, d_dstE=4, d_dstM=15.
REQ-037 D_stall=1 and D_bubble=1 together over 3 clks with changing f_* -> D outputs hold; then D_bubble only -> D_icode=1, D_stat=1.
REQ-038 W_dstE=W_dstM=5 with W_valE=1, W_valM=2 -> r5=2; W_dstE=15 write -> no register changes.
REQ-039 Assert rst_n=0 between clk edges -> D_icode=1 and all register reads return 0 immediately.

Source files
------------

// File: rtl/decode.sv
// Decode stage: D pipeline register, 15x64 register file with write-back port, operand forwarding.
// D fields appear 1 cycle after f_*; decode and forwarding outputs are combinational; D_stall holds, D_bubble loads a nop.
module decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);

  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] S_AOK    = 3'd1;

  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] rf [0:14];

  // Stall wins over bubble; reset leaves a nop in D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_stat  <= S_AOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      if (D_bubble) begin
        D_stat  <= S_AOK;
        D_icode <= I_NOP;
        D_ifun  <= 4'h0;
        D_rA    <= R_NONE;
        D_rB    <= R_NONE;
        D_valC  <= '0;
        D_valP  <= '0;
      end else begin
        D_stat  <= f_stat;
        D_icode <= f_icode;
        D_ifun  <= f_ifun;
        D_rA    <= f_rA;
        D_rB    <= f_rB;
        D_valC  <= f_valC;
        D_valP  <= f_valP;
      end
    end
  end

  // The M port is written last so it wins when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (W_dstE != R_NONE) rf[W_dstE] <= W_valE;
      if (W_dstM != R_NONE) rf[W_dstM] <= W_valM;
    end
  end

  always_comb begin
    d_srcA = R_NONE;
    d_srcB = R_NONE;
    d_dstE = R_NONE;
    d_dstM = R_NONE;
    case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
      I_IRMOVQ: d_dstE = D_rB;
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:   begin d_srcB = R_RSP; d_dstE = R_RSP; end
      I_RET:    begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = R_RSP; d_dstE = R_RSP; end
      I_POPQ:   begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; d_dstM = D_rA; end
      default:  ;
    endcase
  end

  // Youngest producer first; a none source short-circuits before any tag compare.
  always_comb begin
    if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
    else if (d_srcA == R_NONE)                 d_valA = '0;
    else if (d_srcA == e_dstE)                 d_valA = e_valE;
    else if (d_srcA == M_dstM)                 d_valA = m_valM;
    else if (d_srcA == M_dstE)                 d_valA = M_valE;
    else if (d_srcA == W_dstM)                 d_valA = W_valM;
    else if (d_srcA == W_dstE)                 d_valA = W_valE;
    else                                       d_valA = rf[d_srcA];
  end

  always_comb begin
    if (d_srcB == R_NONE)        d_valB = '0;
    else if (d_srcB == e_dstE)   d_valB = e_valE;
    else if (d_srcB == M_dstM)   d_valB = m_valM;
    else if (d_srcB == M_dstE)   d_valB = M_valE;
    else if (d_srcB == W_dstM)   d_valB = W_valM;
    else if (d_srcB == W_dstE)   d_valB = W_valE;
    else                         d_valB = rf[d_srcB];
  end

endmodule

// File: tb/tb_decode.sv
// Directed and randomized checks of decode against a behavioural model of the D stage and register file.
module tb_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        D_stall, D_bubble;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] D_valC, D_valP, d_valA, d_valB;

  int tests = 0;
  int fails = 0;

  // model state
  logic [63:0] m_rf [15];
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_ifun, m_rA, m_rB;
  logic [63:0] m_valC, m_valP;

  decode dut (
    .clk(clk), .rst_n(rst_n), .D_stall(D_stall), .D_bubble(D_bubble),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC), .D_valP(D_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_nop();
    m_stat = 3'd1; m_icode = 4'd1; m_ifun = 4'd0; m_rA = 4'hF; m_rB = 4'hF;
    m_valC = '0; m_valP = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_rf[i] = '0;
    model_nop();
  endtask

  task automatic model_edge();
    if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
    if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
    if (!D_stall) begin
      if (D_bubble) model_nop();
      else begin
        m_stat = f_stat; m_icode = f_icode; m_ifun = f_ifun; m_rA = f_rA; m_rB = f_rB;
        m_valC = f_valC; m_valP = f_valP;
      end
    end
  endtask

  function automatic logic [3:0] exp_srcA();
    if (m_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return m_rA;
    if (m_icode inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_srcB();
    if (m_icode inside {4'h4, 4'h5, 4'h6}) return m_rB;
    if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_dstE();
    if (m_icode inside {4'h2, 4'h3, 4'h6}) return m_rB;
    if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_dstM();
    if (m_icode inside {4'h5, 4'hB}) return m_rA;
    return 4'hF;
  endfunction

  // Ordered list of forwarding sources; first tag that names the register wins.
  function automatic logic [63:0] exp_read(input logic [3:0] src);
    logic [3:0]  tags [5];
    logic [63:0] vals [5];
    logic [63:0] r;
    logic        hit;
    tags = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == 4'hF) return 64'd0;
    hit = 1'b0;
    r = m_rf[src];
    for (int i = 0; i < 5; i++)
      if (!hit && tags[i] == src) begin r = vals[i]; hit = 1'b1; end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/D_stat"},  {61'd0, D_stat},  {61'd0, m_stat});
    chk({tag, "/D_icode"}, {60'd0, D_icode}, {60'd0, m_icode});
    chk({tag, "/D_ifun"},  {60'd0, D_ifun},  {60'd0, m_ifun});
    chk({tag, "/D_valC"},  D_valC, m_valC);
    chk({tag, "/D_valP"},  D_valP, m_valP);
    chk({tag, "/srcA"},    {60'd0, d_srcA}, {60'd0, exp_srcA()});
    chk({tag, "/srcB"},    {60'd0, d_srcB}, {60'd0, exp_srcB()});
    chk({tag, "/dstE"},    {60'd0, d_dstE}, {60'd0, exp_dstE()});
    chk({tag, "/dstM"},    {60'd0, d_dstM}, {60'd0, exp_dstM()});
    chk({tag, "/valA"},    d_valA,
        (m_icode == 4'h7 || m_icode == 4'h8) ? m_valP : exp_read(exp_srcA()));
    chk({tag, "/valB"},    d_valB, exp_read(exp_srcB()));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    D_stall = 0; D_bubble = 0;
    f_stat = 3'd1; f_icode = 4'd1; f_ifun = 0; f_rA = 4'hF; f_rB = 4'hF; f_valC = 0; f_valP = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 5));
  endfunction

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    rst_n = 1'b1;

    // r2=5, r3=7 through the write-back port, then opq rA=2 rB=3
    W_dstE = 4'd2; W_valE = 64'd5; W_dstM = 4'd3; W_valM = 64'd7;
    tick();
    W_dstE = 4'hF; W_dstM = 4'hF;
    f_icode = 4'h6; f_rA = 4'd2; f_rB = 4'd3;
    tick();
    chk("opq_valA", d_valA, 64'd5);
    chk("opq_valB", d_valB, 64'd7);
    chk("opq_dstE", {60'd0, d_dstE}, 64'd3);
    chk("opq_srcA", {60'd0, d_srcA}, 64'd2);
    check_all("opq");

    // forwarding priority: execute beats memory load
    e_dstE = 4'd2; e_valE = 64'h11; M_dstM = 4'd2; m_valM = 64'h22;
    #1 chk("fwd_e", d_valA, 64'h11);
    e_dstE = 4'hF;
    #1 chk("fwd_m", d_valA, 64'h22);
    check_all("fwd");
    M_dstM = 4'hF;

    // call: valA is valP
    f_icode = 4'h8; f_rA = 4'hF; f_rB = 4'hF; f_valC = 64'h100; f_valP = 64'h109;
    tick();
    chk("call_valA", d_valA, 64'h109);
    chk("call_srcB", {60'd0, d_srcB}, 64'd4);
    chk("call_dstE", {60'd0, d_dstE}, 64'd4);
    chk("call_dstM", {60'd0, d_dstM}, 64'hF);

    // stall + bubble: stall wins and D holds
    D_stall = 1; D_bubble = 1;
    for (int i = 0; i < 3; i++) begin
      f_icode = 4'($urandom_range(0, 15)); f_valP = {$urandom, $urandom}; f_stat = 3'($urandom_range(1, 4));
      tick();
      chk("stall_icode", {60'd0, D_icode}, 64'd8);
      chk("stall_valP", D_valP, 64'h109);
    end
    D_stall = 0;
    tick();
    chk("bubble_icode", {60'd0, D_icode}, 64'd1);
    chk("bubble_stat", {61'd0, D_stat}, 64'd1);
    check_all("bubble");
    D_bubble = 0;

    // same-register write on both ports: M wins; read back via rrmovq
    idle_inputs();
    W_dstE = 4'd5; W_valE = 64'd1; W_dstM = 4'd5; W_valM = 64'd2;
    f_icode = 4'h2; f_rA = 4'd5; f_rB = 4'd6;
    tick();
    W_dstM = 4'hF; W_dstE = 4'hF;
    #1 chk("wboth_r5", d_valA, 64'd2);
    W_dstE = 4'hF; W_valE = 64'hDEAD; W_dstM = 4'hF; W_valM = 64'hBEEF;
    for (int r = 0; r < 15; r++) begin
      f_rA = 4'(r);
      tick();
      check_all("rf_scan");
    end
    chk("none_write_r5", m_rf[5], 64'd2);

    // C-F icodes decode nothing and pass status through
    for (int ic = 12; ic < 16; ic++) begin
      f_icode = 4'(ic); f_stat = 3'd4; f_rA = 4'd1; f_rB = 4'd2;
      tick();
      chk("hi_icode_srcA", {60'd0, d_srcA}, 64'hF);
      chk("hi_icode_stat", {61'd0, D_stat}, 64'd4);
    end

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      D_stall  = ($urandom_range(0, 7) == 0);
      D_bubble = ($urandom_range(0, 7) == 0);
      f_stat = 3'($urandom_range(1, 4)); f_icode = 4'($urandom_range(0, 15)); f_ifun = 4'($urandom);
      f_rA = rnd_reg(); f_rB = rnd_reg(); f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      W_dstE = rnd_reg(); W_dstM = rnd_reg(); W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      e_dstE = rnd_reg(); M_dstE = rnd_reg(); M_dstM = rnd_reg();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      #1 check_all("rand_pre");
      tick();
      e_dstE = rnd_reg(); M_dstM = rnd_reg();
      #1 check_all("rand_post");
    end

    // mid-cycle reset discards a pending write and overrides stall
    idle_inputs();
    W_dstE = 4'd7; W_valE = 64'h77; f_icode = 4'h2; f_rA = 4'd7;
    tick();
    W_dstE = 4'hF;
    #1 chk("pre_rst_r7", d_valA, 64'h77);
    W_dstE = 4'd7; W_valE = 64'h99; D_stall = 1;
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("rst_icode", {60'd0, D_icode}, 64'd1);
    chk("rst_valA", d_valA, 64'd0);
    @(posedge clk);
    #2;
    chk("rst_hold_icode", {60'd0, D_icode}, 64'd1);
    W_dstE = 4'hF; D_stall = 0;
    rst_n = 1;
    tick();
    chk("post_rst_r7", d_valA, 64'd0);
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
